// File: rtl/dataout_sink_if.sv
// Local-port flit stream and readback FIFO bundle.
// master drives flits and pops; slave is the sink.
interface dataout_sink_if;
  logic [19:0] datain;
  logic        in_valid;
  logic        rd_en;
  logic [19:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;

  modport master (
    output datain,
    output in_valid,
    output rd_en,
    input  rd_data,
    input  rd_valid,
    input  empty,
    input  full
  );

  modport slave (
    input  datain,
    input  in_valid,
    input  rd_en,
    output rd_data,
    output rd_valid,
    output empty,
    output full
  );
endinterface

// File: rtl/dataout_sink.sv
// Per-node NoC receive sink: dest filter, per-source sequence check,
// readback FIFO, saturating counters and a sticky done flag.
// Ports: clk, rst (async active-low), bus (flit in / FIFO pop out),
// rx_count, dest_err_cnt, seq_err_cnt, drop_cnt, done.
module dataout_sink #(
  parameter logic [3:0] NODE_ID  = 4'd3,
  parameter int         DEPTH    = 32,
  parameter int         NUM_SRC  = 4,
  parameter int         EXPECTED = 30
) (
  input  logic        clk,
  input  logic        rst,
  dataout_sink_if.slave bus,
  output logic [15:0] rx_count,
  output logic [7:0]  dest_err_cnt,
  output logic [7:0]  seq_err_cnt,
  output logic [7:0]  drop_cnt,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   OCC_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   OCC_MAX = DEPTH[AW:0];

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [AW:0]   occ_n;
  logic [7:0]    exp_q [NUM_SRC];

  logic [7:0] f_src;
  logic [7:0] f_seq;
  logic [3:0] f_dst;
  logic       hit;
  logic       miss;
  logic       pop;
  logic       push;
  logic       is_full;
  logic       src_ok;
  logic [7:0] exp_cur;
  logic       seq_bad;

  assign f_src = bus.datain[19:12];
  assign f_seq = bus.datain[11:4];
  assign f_dst = bus.datain[3:0];

  assign hit     = bus.in_valid && (f_dst == NODE_ID);
  assign miss    = bus.in_valid && (f_dst != NODE_ID);
  assign is_full = (occ == OCC_MAX);
  assign pop     = bus.rd_en && (occ != '0);
  // A full FIFO still accepts when a pop frees the head slot.
  assign push    = hit && (!is_full || pop);
  assign src_ok  = (f_src < 8'(NUM_SRC));

  always_comb begin
    exp_cur = 8'h01;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (f_src == 8'(i)) exp_cur = exp_q[i];
    end
  end

  assign seq_bad = hit && (!src_ok || (f_seq != exp_cur));

  always_comb begin
    occ_n = occ;
    unique case (1'b1)
      push && !pop: occ_n = occ + OCC_ONE;
      pop && !push: occ_n = occ - OCC_ONE;
      default:      occ_n = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.datain;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      bus.empty    <= 1'b1;
      bus.full     <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      occ          <= occ_n;
      bus.empty    <= (occ_n == '0);
      bus.full     <= (occ_n == OCC_MAX);
      bus.rd_valid <= pop;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        bus.rd_data <= mem[rd_ptr];
      end
    end
  end

  // Expected-sequence table resyncs to seq+1 on every in-range flit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) exp_q[i] <= 8'h01;
    end else if (hit && src_ok) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (f_src == 8'(i)) exp_q[i] <= f_seq + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_count     <= '0;
      dest_err_cnt <= '0;
      seq_err_cnt  <= '0;
      drop_cnt     <= '0;
      done         <= 1'b0;
    end else begin
      if (hit && rx_count != 16'hFFFF)
        rx_count <= rx_count + 16'd1;
      if (hit && rx_count == 16'(EXPECTED - 1))
        done <= 1'b1;
      if (miss && dest_err_cnt != 8'hFF)
        dest_err_cnt <= dest_err_cnt + 8'd1;
      if (seq_bad && seq_err_cnt != 8'hFF)
        seq_err_cnt <= seq_err_cnt + 8'd1;
      if (hit && !push && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dataout_sink.sv
// Directed bench for dataout_sink: nominal stream, dest filter,
// sequence gap, overflow, full push+pop and mid-stream reset.
module tb_dataout_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] rx_count;
  logic [7:0]  dest_err_cnt;
  logic [7:0]  seq_err_cnt;
  logic [7:0]  drop_cnt;
  logic        done;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dataout_sink_if bus ();

  dataout_sink dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rx_count     (rx_count),
    .dest_err_cnt (dest_err_cnt),
    .seq_err_cnt  (seq_err_cnt),
    .drop_cnt     (drop_cnt),
    .done         (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [19:0] fl(input logic [7:0] s,
                                     input logic [7:0] q,
                                     input logic [3:0] d);
    return {s, q, d};
  endfunction

  task automatic cyc(input logic v,
                     input logic [19:0] d,
                     input logic r);
    @(negedge clk);
    bus.in_valid = v;
    bus.datain   = d;
    bus.rd_en    = r;
  endtask

  task automatic idle();
    cyc(1'b0, 20'h0, 1'b0);
  endtask

  task automatic pop_chk(input string tag, input logic [19:0] e);
    cyc(1'b0, 20'h0, 1'b1);
    @(posedge clk);
    #1;
    chk({tag, ".v"}, 32'(bus.rd_valid), 32'd1);
    chk(tag, 32'(bus.rd_data), 32'(e));
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.datain   = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.datain   = '0;
    do_reset();

    chk("rst.empty", 32'(bus.empty), 32'd1);
    chk("rst.full", 32'(bus.full), 32'd0);
    chk("rst.rdv", 32'(bus.rd_valid), 32'd0);
    chk("rst.rdd", 32'(bus.rd_data), 32'd0);
    chk("rst.rx", 32'(rx_count), 32'd0);
    chk("rst.dest", 32'(dest_err_cnt), 32'd0);
    chk("rst.seq", 32'(seq_err_cnt), 32'd0);
    chk("rst.drop", 32'(drop_cnt), 32'd0);
    chk("rst.done", 32'(done), 32'd0);

    // nominal stream of 30
    for (int i = 1; i <= 29; i++)
      cyc(1'b1, fl(8'h02, 8'(i), 4'h3), 1'b0);
    idle();
    chk("nom.done29", 32'(done), 32'd0);
    chk("nom.rx29", 32'(rx_count), 32'd29);
    cyc(1'b1, 20'h021E3, 1'b0);
    idle();
    chk("nom.rx", 32'(rx_count), 32'd30);
    chk("nom.done", 32'(done), 32'd1);
    chk("nom.seq", 32'(seq_err_cnt), 32'd0);
    chk("nom.dest", 32'(dest_err_cnt), 32'd0);
    chk("nom.drop", 32'(drop_cnt), 32'd0);
    chk("nom.empty0", 32'(bus.empty), 32'd0);
    for (int i = 1; i <= 30; i++)
      pop_chk("nom.rd", fl(8'h02, 8'(i), 4'h3));
    cyc(1'b0, 20'h0, 1'b1);
    @(posedge clk);
    #1;
    chk("nom.xpop.v", 32'(bus.rd_valid), 32'd0);
    chk("nom.xpop.d", 32'(bus.rd_data), 32'h021E3);
    idle();
    chk("nom.empty", 32'(bus.empty), 32'd1);

    // dest filter
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, fl(8'h01, 8'(i), 4'h3), 1'b0);
      if (i % 2 == 0) cyc(1'b1, 20'h01011, 1'b0);
    end
    idle();
    chk("flt.dest", 32'(dest_err_cnt), 32'd5);
    chk("flt.rx", 32'(rx_count), 32'd10);
    chk("flt.seq", 32'(seq_err_cnt), 32'd0);
    for (int i = 1; i <= 10; i++)
      pop_chk("flt.rd", fl(8'h01, 8'(i), 4'h3));
    idle();
    chk("flt.empty", 32'(bus.empty), 32'd1);

    // sequence gap and out-of-range source
    do_reset();
    cyc(1'b1, fl(8'h00, 8'd1, 4'h3), 1'b0);
    cyc(1'b1, fl(8'h00, 8'd2, 4'h3), 1'b0);
    cyc(1'b1, fl(8'h00, 8'd4, 4'h3), 1'b0);
    cyc(1'b1, fl(8'h00, 8'd5, 4'h3), 1'b0);
    cyc(1'b1, fl(8'h07, 8'd1, 4'h3), 1'b0);
    idle();
    chk("gap.seq", 32'(seq_err_cnt), 32'd2);
    cyc(1'b1, fl(8'h00, 8'd6, 4'h3), 1'b0);
    idle();
    chk("gap.resync", 32'(seq_err_cnt), 32'd2);
    chk("gap.rx", 32'(rx_count), 32'd6);

    // overflow
    do_reset();
    for (int i = 1; i <= 32; i++)
      cyc(1'b1, fl(8'h03, 8'(i), 4'h3), 1'b0);
    idle();
    chk("ovf.full32", 32'(bus.full), 32'd1);
    chk("ovf.drop32", 32'(drop_cnt), 32'd0);
    cyc(1'b1, fl(8'h03, 8'd33, 4'h3), 1'b0);
    cyc(1'b1, fl(8'h03, 8'd34, 4'h3), 1'b0);
    idle();
    chk("ovf.drop", 32'(drop_cnt), 32'd2);
    chk("ovf.rx", 32'(rx_count), 32'd34);
    chk("ovf.full", 32'(bus.full), 32'd1);
    chk("ovf.done", 32'(done), 32'd1);

    // full push+pop
    cyc(1'b1, fl(8'h03, 8'd35, 4'h3), 1'b1);
    idle();
    chk("pp.drop", 32'(drop_cnt), 32'd2);
    chk("pp.full", 32'(bus.full), 32'd1);
    chk("pp.rdv", 32'(bus.rd_valid), 32'd1);
    chk("pp.rdd", 32'(bus.rd_data), 32'(fl(8'h03, 8'd1, 4'h3)));
    chk("pp.seq", 32'(seq_err_cnt), 32'd0);
    for (int i = 2; i <= 32; i++)
      pop_chk("pp.rd", fl(8'h03, 8'(i), 4'h3));
    pop_chk("pp.last", fl(8'h03, 8'd35, 4'h3));
    idle();
    chk("pp.empty", 32'(bus.empty), 32'd1);

    // reset mid-stream
    for (int i = 1; i <= 10; i++)
      cyc(1'b1, fl(8'h00, 8'(i), 4'h3), 1'b0);
    cyc(1'b1, 20'h01011, 1'b0);
    idle();
    chk("mid.pre.rx", 32'(rx_count), 32'd45);
    chk("mid.pre.dest", 32'(dest_err_cnt), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid.rx", 32'(rx_count), 32'd0);
    chk("mid.dest", 32'(dest_err_cnt), 32'd0);
    chk("mid.drop", 32'(drop_cnt), 32'd0);
    chk("mid.done", 32'(done), 32'd0);
    chk("mid.empty", 32'(bus.empty), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, fl(8'h00, 8'd1, 4'h3), 1'b0);
    idle();
    chk("mid.seq", 32'(seq_err_cnt), 32'd0);
    chk("mid.rx1", 32'(rx_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
